aes_buffer_unit: RTL and testbench

Execution-side responder for the custom-buffer instruction group (opcode 0101011). It consumes the decoded control strobes load_temp, plus1, AES_W/key_size and enable_AES, and stages operand words into an internal word buffer. It configures key length, launches the external AES core through a start/done handshake, and holds the 128-bit result for readback. It sits in EX beside the ALU and drives the pipeline stall while the AES core runs.

---
 rtl/aes_buffer_unit.sv | 127 ++++++++++++
 tb/tb_aes_buffer_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_buffer_unit.sv
// Operand staging buffer and start/done handshake for the custom-buffer AES instruction group.
// Stages plaintext and key words, configures key length, launches the AES core and holds the 128-bit result.
module aes_buffer_unit #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BUF_WORDS = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_temp,
  input  logic              plus1,
  input  logic              aes_w,
  input  logic [1:0]        key_size,
  input  logic              enable_aes,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        rd_idx,
  output logic              aes_start,
  output logic [127:0]      aes_block,
  output logic [255:0]      aes_key,
  output logic [1:0]        aes_key_size,
  input  logic              aes_done,
  input  logic [127:0]      aes_result,
  output logic [DATA_W-1:0] rdata,
  output logic              result_valid,
  output logic              busy,
  output logic              stall,
  output logic              cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(BUF_WORDS - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] buf_q [BUF_WORDS];
  logic [3:0]        wptr_q;
  logic [1:0]        cfg_q;
  logic              cfg_err_q;
  logic              result_valid_q;
  logic [127:0]      result_q;
  logic              cmd_any;
  logic              done_hit;
  logic [3:0]        key_words;

  assign busy         = (state_q == S_START) || (state_q == S_WAIT);
  assign cmd_any      = load_temp | plus1 | aes_w | enable_aes;
  assign stall        = busy & cmd_any;
  assign aes_start    = (state_q == S_START);
  assign done_hit     = (state_q == S_WAIT) && aes_done;
  assign aes_key_size = cfg_q;
  assign cfg_err      = cfg_err_q;
  assign result_valid = result_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (enable_aes) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (aes_done) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BUF_WORDS; i++) buf_q[i] <= '0;
      wptr_q         <= '0;
      cfg_q          <= '0;
      cfg_err_q      <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      if (done_hit) result_q <= aes_result;
      // Buffer and config are frozen while the core owns aes_block/aes_key.
      if (!busy) begin
        if (load_temp && (wptr_q <= LAST_IDX)) buf_q[wptr_q] <= wdata;
        if (aes_w) begin
          wptr_q <= '0;
          if (key_size == 2'd3) begin
            cfg_q     <= 2'd0;
            cfg_err_q <= 1'b1;
          end else begin
            cfg_q <= key_size;
          end
        end else if (plus1) begin
          wptr_q <= (wptr_q == LAST_IDX) ? 4'd0 : wptr_q + 4'd1;
        end
      end
      if (done_hit)
        result_valid_q <= 1'b1;
      else if (!busy && (aes_w || ((state_q == S_IDLE) && enable_aes)))
        result_valid_q <= 1'b0;
    end
  end

  always_comb begin
    unique case (cfg_q)
      2'd1:    key_words = 4'd6;
      2'd2:    key_words = 4'd8;
      default: key_words = 4'd4;
    endcase
  end

  always_comb begin
    aes_block = '0;
    aes_key   = '0;
    for (int unsigned i = 0; i < 4; i++)
      aes_block[(3-i)*DATA_W +: DATA_W] = buf_q[i];
    for (int unsigned i = 0; i < 8; i++)
      if (4'(i) < key_words) aes_key[(7-i)*DATA_W +: DATA_W] = buf_q[4+i];
  end

  always_comb begin
    unique case (rd_idx)
      2'd0:    rdata = result_q[127:96];
      2'd1:    rdata = result_q[95:64];
      2'd2:    rdata = result_q[63:32];
      default: rdata = result_q[31:0];
    endcase
  end

endmodule

// File: tb/tb_aes_buffer_unit.sv
// Self-checking bench for aes_buffer_unit: key-size table, scoreboarded AES handshake, wrap/stall/reset sequences.
module tb_aes_buffer_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_temp, plus1, aes_w, enable_aes, aes_done;
  logic [1:0]   key_size, rd_idx;
  logic [31:0]  wdata;
  logic [127:0] aes_result;
  logic         aes_start, result_valid, busy, stall, cfg_err;
  logic [127:0] aes_block;
  logic [255:0] aes_key;
  logic [1:0]   aes_key_size;
  logic [31:0]  rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] scb_q[$];

  aes_buffer_unit #(.DATA_W(32), .BUF_WORDS(12)) dut (
    .clk(clk), .rst_n(rst_n), .load_temp(load_temp), .plus1(plus1),
    .aes_w(aes_w), .key_size(key_size), .enable_aes(enable_aes), .wdata(wdata),
    .rd_idx(rd_idx), .aes_start(aes_start), .aes_block(aes_block), .aes_key(aes_key),
    .aes_key_size(aes_key_size), .aes_done(aes_done), .aes_result(aes_result),
    .rdata(rdata), .result_valid(result_valid), .busy(busy), .stall(stall),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   ks;
    logic [1:0]   exp_ks;
    logic         exp_err;
    logic [255:0] exp_key;
  } cfg_vec_t;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_temp = 0; plus1 = 0; aes_w = 0; enable_aes = 0; aes_done = 0;
    key_size = 0; wdata = '0;
  endtask

  task automatic do_aes_w(input logic [1:0] ks);
    aes_w = 1; key_size = ks;
    tick();
    idle_inputs();
  endtask

  task automatic do_load(input logic [31:0] d, input logic inc);
    load_temp = 1; plus1 = inc; wdata = d;
    tick();
    idle_inputs();
  endtask

  // Pop one expected result and compare every readback word.
  task automatic check_result();
    logic [127:0] e;
    if (scb_q.size() == 0) begin
      check("scoreboard_nonempty", 1'b0, 1'b1);
    end else begin
      e = scb_q.pop_front();
      for (int i = 0; i < 4; i++) begin
        rd_idx = 2'(i);
        #1;
        check($sformatf("rdata[%0d]", i), rdata, e[127-32*i -: 32]);
      end
      rd_idx = 2'd0;
    end
  endtask

  logic [31:0]  words [12];
  logic [255:0] key_full;
  logic [127:0] blk_exp;
  logic [127:0] aes_res;
  cfg_vec_t     cfg_tab [5];
  int           busy_cnt, start_cnt;

  initial begin
    words = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF,
              32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
              32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F};
    key_full = {words[4], words[5], words[6], words[7], words[8], words[9], words[10], words[11]};
    blk_exp  = {words[0], words[1], words[2], words[3]};
    aes_res  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

    cfg_tab[0] = '{ks: 2'd1, exp_ks: 2'd1, exp_err: 1'b0, exp_key: {key_full[255:64], 64'h0}};
    cfg_tab[1] = '{ks: 2'd2, exp_ks: 2'd2, exp_err: 1'b0, exp_key: key_full};
    cfg_tab[2] = '{ks: 2'd3, exp_ks: 2'd0, exp_err: 1'b1, exp_key: {key_full[255:128], 128'h0}};
    cfg_tab[3] = '{ks: 2'd0, exp_ks: 2'd0, exp_err: 1'b1, exp_key: {key_full[255:128], 128'h0}};
    cfg_tab[4] = '{ks: 2'd2, exp_ks: 2'd2, exp_err: 1'b1, exp_key: key_full};

    idle_inputs();
    rd_idx = 0; aes_result = '0; rst_n = 0;
    repeat (2) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_start", aes_start, 1'b0);
    check("rst_valid", result_valid, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);
    check("rst_key_size", aes_key_size, 2'd0);
    check("rst_block", aes_block, 128'h0);
    check("rst_rdata", rdata, 32'h0);
    rst_n = 1;
    tick();

    // Stage plaintext and full 256-bit key with AES-128 config.
    do_aes_w(2'd0);
    for (int i = 0; i < 12; i++) do_load(words[i], 1'b1);
    check("load_block", aes_block, blk_exp);
    check("load_key128", aes_key, {key_full[255:128], 128'h0});

    // AES launch; core answers on the 10th WAIT cycle.
    scb_q.push_back(aes_res);
    enable_aes = 1;
    #1;
    check("stall_idle_cmd", stall, 1'b0);
    tick();
    idle_inputs();
    busy_cnt = 0; start_cnt = 0;
    if (busy) busy_cnt++;
    if (aes_start) start_cnt++;
    tick();
    for (int k = 1; k <= 10; k++) begin
      if (busy) busy_cnt++;
      if (aes_start) start_cnt++;
      if (k == 3) begin
        load_temp = 1; plus1 = 1; wdata = 32'hDEADBEEF;
        #1;
        check("stall_busy", stall, 1'b1);
      end
      if (k == 10) begin
        aes_done = 1; aes_result = aes_res;
      end
      tick();
      idle_inputs();
      aes_result = '0;
    end
    check("busy_cycles", busy_cnt, 11);
    check("start_pulses", start_cnt, 1);
    check("done_busy", busy, 1'b0);
    check("done_start", aes_start, 1'b0);
    check("done_valid", result_valid, 1'b1);
    if (result_valid) check_result();
    tick();
    check("valid_hold", result_valid, 1'b1);
    check("block_frozen", aes_block, blk_exp);

    // wptr wrapped to 0 after 12 loads and did not move while busy.
    do_load(32'hA5A5A5A5, 1'b0);
    check("wrap_word0", aes_block[127:96], 32'hA5A5A5A5);
    check("word1_kept", aes_block[95:64], words[1]);

    do_aes_w(2'd0);
    check("aes_w_clr_valid", result_valid, 1'b0);
    for (int i = 0; i < 12; i++) begin
      plus1 = 1;
      tick();
      idle_inputs();
    end
    do_load(words[0], 1'b1);
    do_load(words[1], 1'b0);
    check("wrap_block", aes_block, blk_exp);

    for (int i = 0; i < 5; i++) begin
      do_aes_w(cfg_tab[i].ks);
      check($sformatf("cfg%0d_ks", i), aes_key_size, cfg_tab[i].exp_ks);
      check($sformatf("cfg%0d_err", i), cfg_err, cfg_tab[i].exp_err);
      check($sformatf("cfg%0d_key", i), aes_key, cfg_tab[i].exp_key);
    end

    // Reset in the middle of WAIT; a late aes_done must be ignored.
    enable_aes = 1;
    tick();
    idle_inputs();
    tick();
    check("mid_busy", busy, 1'b1);
    rst_n = 0;
    #2;
    check("async_rst_busy", busy, 1'b0);
    tick();
    rst_n = 1;
    tick();
    aes_done = 1; aes_result = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    tick();
    idle_inputs();
    aes_result = '0;
    check("late_done_busy", busy, 1'b0);
    check("late_done_valid", result_valid, 1'b0);
    check("late_done_start", aes_start, 1'b0);
    check("late_done_rdata", rdata, 32'h0);
    check("rst_cfg_err2", cfg_err, 1'b0);
    tick();
    check("idle_start", aes_start, 1'b0);
    check("scoreboard_drained", scb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
